dialog_seq_ctrl: RTL and testbench
==================================

Name: dialog_seq_ctrl

Overview:
Sequencer for the in-game dialog text path. It decides when a dialog is open, which text page the text ROMs and font ROMs render, and how many characters of that page are revealed (typewriter effect, paced by frame ticks). It turns key presses into page advance, skip and abort actions. It raises the sticky game-progress flags door and item2 when specific pages are acknowledged. It sits between the key input and the dialog render block.

Parameters:
NUM_PAGES, 4, number of dialog pages in one conversation (min 2)
LINE_CHARS, 32, characters per page; reveal saturates here (max 63)
TICKS_PER_CHAR, 2, frame ticks per revealed character (min 1)
DOOR_PAGE, 2, page whose acknowledgement sets door
ITEM_PAGE, 3, page whose acknowledgement sets item2

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
key  input  4  key levels, already debounced; [0]=advance/skip, [3]=abort, [2:1] unused
frame_tick  input  1  one-cycle pulse per video frame
trigger  input  1  level; player is at the dialog point
dialog_active  output  1  dialog box visible
page  output  $clog2(NUM_PAGES)  page index for the text ROMs
reveal  output  6  number of characters shown, 0..LINE_CHARS
page_done  output  1  page fully revealed, waiting for key
door  output  1  sticky flag, door unlocked
item2  output  1  sticky flag, item 2 granted

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- All outputs are registered. Each takes effect on the clock edge after the cycle in which its cause is sampled.
- Reset: state=IDLE, dialog_active=0, page=0, reveal=0, page_done=0, door=0, item2=0, tick_cnt=0.
- Reset also sets key_q=4'b1111, so a key held through reset is not counted as a press.
- Key press detection: press[i] = key[i] & ~key_q[i]; key_q <= key every cycle. A press is one cycle wide. A held key never repeats.
- State machine: IDLE, REVEAL, WAIT_KEY.
- IDLE:
  - trigger=1 -> REVEAL with page=0, reveal=0, tick_cnt=0, dialog_active=1.
  - Key presses in IDLE are ignored.
- REVEAL (dialog_active=1, page_done=0):
  - On frame_tick: if tick_cnt==TICKS_PER_CHAR-1, then tick_cnt=0 and reveal++; otherwise tick_cnt++.
  - When the increment makes reveal==LINE_CHARS, go to WAIT_KEY on that same edge.
  - press[0] -> reveal=LINE_CHARS, tick_cnt=0, go to WAIT_KEY (skip). Skip takes priority over a coincident frame_tick.
- WAIT_KEY (page_done=1, reveal=LINE_CHARS):
  - press[0] with page==DOOR_PAGE -> door=1. press[0] with page==ITEM_PAGE -> item2=1.
  - Then, if page==NUM_PAGES-1: go to IDLE with dialog_active=0, page=0, reveal=0, page_done=0.
  - Otherwise: page++, reveal=0, page_done=0, tick_cnt=0, go to REVEAL.
  - frame_tick is ignored in this state.
- Abort: press[3] in REVEAL or WAIT_KEY -> IDLE with dialog_active=0, page=0, reveal=0, page_done=0. door and item2 are unchanged.
  - press[3] takes priority over a coincident press[0], so no flag is set on that edge.
- trigger while dialog is active: ignored.
- trigger still high after the dialog ends or is aborted: restarts the dialog on the next cycle. Preventing this is the top level's job.
- door and item2 clear only on rst. Re-acknowledging an already-set flag leaves it at 1.
- Reset in any state returns to reset values on the next edge, including door and item2.
- Width: reveal and tick_cnt never exceed LINE_CHARS and TICKS_PER_CHAR-1 respectively. No wrap-around.

Test Plan:
- Reset, then trigger=1 for 1 cycle -> dialog_active=1, page=0, reveal=0. Apply 64 frame_ticks -> reveal=32 and page_done=1 on the edge of the 64th tick; an extra tick leaves reveal=32.
- Start at page 0, press key[0] after 10 frame_ticks (reveal=5) -> next edge reveal=32, page_done=1. Second press -> page=1, reveal=0, page_done=0.
- Skip and advance through pages 0..3 -> door=1 after leaving page 2, item2=1 after leaving page 3. Then dialog_active=0, page=0, and door/item2 stay 1 across a new trigger.
- On page 2 in WAIT_KEY, press key[0] and key[3] in the same cycle -> IDLE, door=0, page=0. Hold key[0] for 20 cycles in WAIT_KEY -> exactly one page advance.
- Hold key[0] through reset release -> no skip in the first dialog. Assert rst mid-REVEAL on page 1 with door=1 -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/dialog_seq_ctrl.sv
// Dialog text sequencer.
// Decides when the dialog box is open and which page the text ROMs render.
// Reveals the page one character at a time, paced by frame ticks.
// Key[0] skips the reveal or acknowledges the page; key[3] aborts the dialog.
// Acknowledging DOOR_PAGE / ITEM_PAGE raises sticky progress flags.
module dialog_seq_ctrl #(
   parameter int NUM_PAGES      = 4,
   parameter int LINE_CHARS     = 32,
   parameter int TICKS_PER_CHAR = 2,
   parameter int DOOR_PAGE      = 2,
   parameter int ITEM_PAGE      = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [3:0]                   key,
   input  logic                         frame_tick,
   input  logic                         trigger,
   output logic                         dialog_active,
   output logic [$clog2(NUM_PAGES)-1:0] page,
   output logic [5:0]                   reveal,
   output logic                         page_done,
   output logic                         door,
   output logic                         item2
);

   localparam int PW = $clog2(NUM_PAGES);
   // The tick counter keeps at least one bit so a one-tick pace still elaborates.
   localparam int TW = (TICKS_PER_CHAR > 1) ? $clog2(TICKS_PER_CHAR) : 1;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_REVEAL   = 2'd1;
   localparam logic [1:0] ST_WAIT_KEY = 2'd2;

   localparam logic [5:0]    REVEAL_MAX = 6'(LINE_CHARS);
   localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_CHAR - 1);
   localparam logic [PW-1:0] LAST_PAGE  = PW'(NUM_PAGES - 1);
   localparam logic [PW-1:0] DOOR_IDX   = PW'(DOOR_PAGE);
   localparam logic [PW-1:0] ITEM_IDX   = PW'(ITEM_PAGE);

   logic [1:0]    state;
   logic [1:0]    state_nx;
   logic [3:0]    key_q;
   logic [3:0]    press;
   logic [TW-1:0] tick_cnt;
   logic [TW-1:0] tick_nx;
   logic [PW-1:0] page_nx;
   logic [5:0]    reveal_nx;
   logic          active_nx;
   logic          done_nx;
   logic          door_nx;
   logic          item_nx;

   // Rising edges of the key levels; a held key produces exactly one press.
   assign press = key & ~key_q;

   // Keys 1 and 2 carry no function in this block.
   logic unused_keys;
   assign unused_keys = ^press[2:1];

   // Next-state and next-output decision for the dialog sequencer.
   always_comb begin
      // NOTE: every combinational output starts from its held value so no path can infer a latch.
      state_nx  = state;
      tick_nx   = tick_cnt;
      page_nx   = page;
      reveal_nx = reveal;
      active_nx = dialog_active;
      done_nx   = page_done;
      door_nx   = door;
      item_nx   = item2;

      case (state)
         ST_IDLE: begin
            // Key presses are meaningless without an open dialog.
            if (trigger) begin
               state_nx  = ST_REVEAL;
               active_nx = 1'b1;
               page_nx   = '0;
               reveal_nx = '0;
               tick_nx   = '0;
               done_nx   = 1'b0;
            end
         end

         ST_REVEAL: begin
            if (press[3]) begin
               // Abort wins over everything else on the same edge.
               state_nx  = ST_IDLE;
               active_nx = 1'b0;
               page_nx   = '0;
               reveal_nx = '0;
               tick_nx   = '0;
               done_nx   = 1'b0;
            end else if (press[0]) begin
               // Skip: show the whole page at once, even if a tick coincides.
               state_nx  = ST_WAIT_KEY;
               reveal_nx = REVEAL_MAX;
               tick_nx   = '0;
               done_nx   = 1'b1;
            end else if (frame_tick) begin
               if (tick_cnt == TICK_LAST) begin
                  tick_nx   = '0;
                  reveal_nx = reveal + 6'd1;
                  // The character that completes the line ends the reveal on this edge.
                  if (reveal_nx == REVEAL_MAX) begin
                     state_nx = ST_WAIT_KEY;
                     done_nx  = 1'b1;
                  end
               end else begin
                  tick_nx = tick_cnt + TW'(1);
               end
            end
         end

         ST_WAIT_KEY: begin
            // Frame ticks are ignored: the page is fully shown.
            if (press[3]) begin
               state_nx  = ST_IDLE;
               active_nx = 1'b0;
               page_nx   = '0;
               reveal_nx = '0;
               tick_nx   = '0;
               done_nx   = 1'b0;
            end else if (press[0]) begin
               if (page == DOOR_IDX) begin
                  door_nx = 1'b1;
               end
               if (page == ITEM_IDX) begin
                  item_nx = 1'b1;
               end
               if (page == LAST_PAGE) begin
                  // Conversation finished: close the box.
                  state_nx  = ST_IDLE;
                  active_nx = 1'b0;
                  page_nx   = '0;
                  reveal_nx = '0;
                  tick_nx   = '0;
                  done_nx   = 1'b0;
               end else begin
                  state_nx  = ST_REVEAL;
                  page_nx   = page + PW'(1);
                  reveal_nx = '0;
                  tick_nx   = '0;
                  done_nx   = 1'b0;
               end
            end
         end

         default: begin
            // Unreachable encodings fall back to a closed dialog.
            state_nx  = ST_IDLE;
            active_nx = 1'b0;
            page_nx   = '0;
            reveal_nx = '0;
            tick_nx   = '0;
            done_nx   = 1'b0;
         end
      endcase
   end

   // Register state, key history and all outputs; synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         // A key already down when reset lifts must not look like a fresh press.
         key_q         <= 4'b1111;
         tick_cnt      <= '0;
         page          <= '0;
         reveal        <= '0;
         dialog_active <= 1'b0;
         page_done     <= 1'b0;
         door          <= 1'b0;
         item2         <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state         <= state_nx;
         key_q         <= key;
         tick_cnt      <= tick_nx;
         page          <= page_nx;
         reveal        <= reveal_nx;
         dialog_active <= active_nx;
         page_done     <= done_nx;
         door          <= door_nx;
         item2         <= item_nx;
      end
   end

endmodule

// File: tb/tb_dialog_seq_ctrl.sv
// Self-checking bench for dialog_seq_ctrl: a vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_dialog_seq_ctrl;

   localparam int NUM_PAGES  = 4;
   localparam int LINE_CHARS = 32;
   localparam int TPC        = 2;
   localparam int DOOR_PAGE  = 2;
   localparam int ITEM_PAGE  = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] key;
   logic       frame_tick;
   logic       trigger;
   logic       dialog_active;
   logic [1:0] page;
   logic [5:0] reveal;
   logic       page_done;
   logic       door;
   logic       item2;

   int n_total = 0;
   int n_pass  = 0;

   // Behavioural model: counts frame ticks on the current page and derives
   // the revealed character count arithmetically.
   bit         m_active;
   int         m_page;
   int         m_ticks;
   bit         m_skipped;
   bit         m_door;
   bit         m_item;
   logic [3:0] m_kprev;

   typedef struct {
      logic       r;
      logic [3:0] k;
      logic       ft;
      logic       tr;
      logic       e_active;
      int         e_page;
      int         e_reveal;
      logic       e_done;
      logic       e_door;
      logic       e_item;
   } vec_t;

   vec_t vecs[14];

   dialog_seq_ctrl #(
      .NUM_PAGES(NUM_PAGES),
      .LINE_CHARS(LINE_CHARS),
      .TICKS_PER_CHAR(TPC),
      .DOOR_PAGE(DOOR_PAGE),
      .ITEM_PAGE(ITEM_PAGE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .key(key),
      .frame_tick(frame_tick),
      .trigger(trigger),
      .dialog_active(dialog_active),
      .page(page),
      .reveal(reveal),
      .page_done(page_done),
      .door(door),
      .item2(item2)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout, expected run to finish");
      $fatal(1, "watchdog expired");
   end

   function automatic int m_reveal();
      int chars;
      if (!m_active) return 0;
      if (m_skipped) return LINE_CHARS;
      chars = m_ticks / TPC;
      return (chars < LINE_CHARS) ? chars : LINE_CHARS;
   endfunction

   task automatic model_step(input logic r, input logic [3:0] k, input logic ft, input logic tr);
      logic [3:0] pr;
      bit         done;
      if (r) begin
         m_active = 0; m_page = 0; m_ticks = 0; m_skipped = 0;
         m_door = 0; m_item = 0; m_kprev = 4'b1111;
         return;
      end
      pr = k & ~m_kprev;
      m_kprev = k;
      if (!m_active) begin
         if (tr) begin
            m_active = 1; m_page = 0; m_ticks = 0; m_skipped = 0;
         end
      end else begin
         done = (m_reveal() == LINE_CHARS);
         if (pr[3]) begin
            m_active = 0; m_page = 0; m_ticks = 0; m_skipped = 0;
         end else if (!done) begin
            if (pr[0]) m_skipped = 1;
            else if (ft) m_ticks++;
         end else if (pr[0]) begin
            if (m_page == DOOR_PAGE) m_door = 1;
            if (m_page == ITEM_PAGE) m_item = 1;
            if (m_page == NUM_PAGES - 1) begin
               m_active = 0; m_page = 0;
            end else begin
               m_page++;
            end
            m_ticks = 0; m_skipped = 0;
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic check_model(input string tag);
      check({tag, ".active"}, 32'(dialog_active), 32'(m_active));
      check({tag, ".page"},   32'(page),          m_page);
      check({tag, ".reveal"}, 32'(reveal),        m_reveal());
      check({tag, ".done"},   32'(page_done),     32'(m_active && m_reveal() == LINE_CHARS));
      check({tag, ".door"},   32'(door),          32'(m_door));
      check({tag, ".item2"},  32'(item2),         32'(m_item));
   endtask

   // Drive one cycle of inputs, advance the model with the same inputs, sample after the edge.
   task automatic step(input logic r, input logic [3:0] k, input logic ft, input logic tr);
      rst = r; key = k; frame_tick = ft; trigger = tr;
      @(posedge clk);
      model_step(r, k, ft, tr);
      #1;
   endtask

   // Skip the current page, release, acknowledge it, release.
   task automatic skip_and_ack(input string tag);
      step(0, 4'b0001, 0, 0); check_model({tag, ".skip"});
      step(0, 4'b0000, 0, 0);
      step(0, 4'b0001, 0, 0); check_model({tag, ".ack"});
      step(0, 4'b0000, 0, 0);
   endtask

   initial begin
      logic [3:0] kr;

      rst = 1; key = 0; frame_tick = 0; trigger = 0;

      // ---------------- vector table ----------------
      //              r  k        ft tr  act pg rev dn dr it
      vecs[0]  = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 0, 0,  1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 0, 0,  1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 0, 0,  1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 0, 1,  1'b0, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 0, 1,  1'b0, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 0, 2,  1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 4'h1, 1'b1, 1'b0, 1'b1, 0, 32, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 4'h1, 1'b1, 1'b0, 1'b1, 0, 32, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 0, 32, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 4'h1, 1'b0, 1'b0, 1'b1, 1, 0,  1'b0, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 4'h8, 1'b0, 1'b0, 1'b0, 0, 0,  1'b0, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 0, 0,  1'b0, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 0, 0,  1'b0, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 4'h9, 1'b0, 1'b0, 1'b0, 0, 0,  1'b0, 1'b0, 1'b0};

      for (int i = 0; i < 14; i++) begin
         step(vecs[i].r, vecs[i].k, vecs[i].ft, vecs[i].tr);
         check($sformatf("vec%0d.active", i), 32'(dialog_active), 32'(vecs[i].e_active));
         check($sformatf("vec%0d.page", i),   32'(page),          vecs[i].e_page);
         check($sformatf("vec%0d.reveal", i), 32'(reveal),        vecs[i].e_reveal);
         check($sformatf("vec%0d.done", i),   32'(page_done),     32'(vecs[i].e_done));
         check($sformatf("vec%0d.door", i),   32'(door),          32'(vecs[i].e_door));
         check($sformatf("vec%0d.item2", i),  32'(item2),         32'(vecs[i].e_item));
      end

      // ---------------- full typewriter reveal ----------------
      step(1, 4'h0, 0, 0);
      step(0, 4'h0, 0, 1);
      check("rev.start.active", 32'(dialog_active), 1);
      for (int i = 0; i < 64; i++) begin
         step(0, 4'h0, 1, 0);
         check_model($sformatf("rev.t%0d", i));
         if (i == 62) begin
            check("rev.t62.reveal", 32'(reveal), 31);
            check("rev.t62.done",   32'(page_done), 0);
         end
      end
      check("rev.t64.reveal", 32'(reveal), 32);
      check("rev.t64.done",   32'(page_done), 1);
      step(0, 4'h0, 1, 0);
      check("rev.extra.reveal", 32'(reveal), 32);

      // ---------------- skip at reveal=5, then advance ----------------
      step(1, 4'h0, 0, 0);
      step(0, 4'h0, 0, 1);
      for (int i = 0; i < 10; i++) step(0, 4'h0, 1, 0);
      check("skip.pre.reveal", 32'(reveal), 5);
      step(0, 4'h1, 0, 0);
      check("skip.reveal", 32'(reveal), 32);
      check("skip.done",   32'(page_done), 1);
      step(0, 4'h0, 0, 0);
      step(0, 4'h1, 0, 0);
      check("adv.page",   32'(page), 1);
      check("adv.reveal", 32'(reveal), 0);
      check("adv.done",   32'(page_done), 0);
      step(0, 4'h0, 0, 0);

      // ---------------- full walkthrough with flags ----------------
      step(1, 4'h0, 0, 0);
      step(0, 4'h0, 0, 1);
      step(0, 4'h0, 0, 0);
      for (int p = 0; p < NUM_PAGES; p++) begin
         skip_and_ack($sformatf("walk.p%0d", p));
         if (p == DOOR_PAGE) begin
            check("walk.door_after_p2", 32'(door), 1);
            check("walk.item_after_p2", 32'(item2), 0);
         end
      end
      check("walk.end.active", 32'(dialog_active), 0);
      check("walk.end.page",   32'(page), 0);
      check("walk.end.item2",  32'(item2), 1);
      step(0, 4'h0, 0, 1);
      check("walk.retrig.active", 32'(dialog_active), 1);
      check("walk.retrig.door",   32'(door), 1);
      check("walk.retrig.item2",  32'(item2), 1);
      step(0, 4'h0, 0, 0);

      // ---------------- reset mid-REVEAL on page 1 with door set ----------------
      skip_and_ack("rst.p0");
      step(0, 4'h0, 1, 0);
      step(0, 4'h0, 1, 0);
      step(0, 4'h0, 1, 0);
      check("rst.pre.page", 32'(page), 1);
      step(1, 4'h0, 0, 0);
      check("rst.active", 32'(dialog_active), 0);
      check("rst.page",   32'(page), 0);
      check("rst.reveal", 32'(reveal), 0);
      check("rst.done",   32'(page_done), 0);
      check("rst.door",   32'(door), 0);
      check("rst.item2",  32'(item2), 0);

      // ---------------- abort beats acknowledge on page 2 ----------------
      step(0, 4'h0, 0, 1);
      step(0, 4'h0, 0, 0);
      skip_and_ack("abt.p0");
      skip_and_ack("abt.p1");
      step(0, 4'h1, 0, 0);
      check("abt.wait.page", 32'(page), 2);
      check("abt.wait.done", 32'(page_done), 1);
      step(0, 4'h0, 0, 0);
      step(0, 4'h9, 0, 0);
      check("abt.active", 32'(dialog_active), 0);
      check("abt.page",   32'(page), 0);
      check("abt.door",   32'(door), 0);
      step(0, 4'h0, 0, 0);

      // ---------------- held key advances exactly once ----------------
      step(0, 4'h0, 0, 1);
      step(0, 4'h1, 0, 0);
      step(0, 4'h0, 0, 0);
      for (int i = 0; i < 20; i++) step(0, 4'h1, 0, 0);
      check("hold.page",   32'(page), 1);
      check("hold.reveal", 32'(reveal), 0);
      check("hold.done",   32'(page_done), 0);
      step(0, 4'h0, 0, 0);

      // ---------------- key held through reset release ----------------
      step(1, 4'h1, 0, 0);
      step(1, 4'h1, 0, 0);
      step(0, 4'h1, 0, 1);
      step(0, 4'h1, 1, 0);
      step(0, 4'h1, 1, 0);
      check("held_rst.reveal", 32'(reveal), 1);
      check("held_rst.done",   32'(page_done), 0);
      step(0, 4'h0, 0, 0);

      // ---------------- randomized run against the model ----------------
      step(1, 4'h0, 0, 0);
      kr = 4'h0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) kr = 4'($urandom_range(0, 15));
         step(($urandom_range(0, 499) == 0), kr,
              1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
         check_model($sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
